// File: rtl/avalon_mem_master.sv
// Purpose : bridges one word-granular CPU memory request at a time onto an Avalon-MM master port.
// Latency : accept at edge E, strobe in E+1, resp_valid in E+2 with zero wait states (+1 per waitrequest cycle).
// Backpr. : req_ready is high only in IDLE; bus outputs are held stable while mem_waitrequest=1.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req_*                 core request (valid/ready handshake, write, address, byteenable, writedata)
//   resp_*                one-cycle completion pulse with error flag and captured read word
//   mem_*                 Avalon-MM master (address, read, write, byteenable, writedata, waitrequest, readdata)
//
// Optional build macro: MEM_TIMEOUT_EN -- abort an access stuck in waitrequest for
// TIMEOUT_CYCLES cycles and report it as an error response.
module avalon_mem_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TCNT_W         = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_byteenable,
  input  logic [31:0] req_writedata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_byteenable_q, mem_byteenable_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_readdata_q, resp_readdata_d;
`ifdef MEM_TIMEOUT_EN
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_error     = resp_error_q;
  assign resp_readdata  = resp_readdata_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_byteenable = mem_byteenable_q;
  assign mem_writedata  = mem_writedata_q;

  always_comb begin
    state_d          = state_q;
    mem_address_d    = mem_address_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_byteenable_d = mem_byteenable_q;
    mem_writedata_d  = mem_writedata_q;
    resp_valid_d     = 1'b0;
    resp_error_d     = 1'b0;
    resp_readdata_d  = resp_readdata_q;
`ifdef MEM_TIMEOUT_EN
    tcnt_d           = tcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // The strobe flops double as the latched direction of the request.
          mem_address_d    = req_address;
          mem_byteenable_d = req_byteenable;
          mem_writedata_d  = req_writedata;
          if (req_address[1:0] != 2'b00) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_byteenable == 4'b0000) begin
            // Nothing to transfer: complete immediately without touching the bus.
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            mem_read_d  = ~req_write;
            mem_write_d = req_write;
`ifdef MEM_TIMEOUT_EN
            tcnt_d      = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (!mem_waitrequest) begin
          if (mem_read_q) begin
            resp_readdata_d = mem_readdata;
          end
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        // The count reaches TIMEOUT_CYCLES at this edge: abandon the access.
        else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      mem_address_q    <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_byteenable_q <= '0;
      mem_writedata_q  <= '0;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_readdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      tcnt_q           <= '0;
`endif
    end else begin
      state_q          <= state_d;
      mem_address_q    <= mem_address_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_byteenable_q <= mem_byteenable_d;
      mem_writedata_q  <= mem_writedata_d;
      resp_valid_q     <= resp_valid_d;
      resp_error_q     <= resp_error_d;
      resp_readdata_q  <= resp_readdata_d;
`ifdef MEM_TIMEOUT_EN
      tcnt_q           <= tcnt_d;
`endif
    end
  end

endmodule
